// File: rtl/uart_tx_fifo_if.sv
// Write port of the buffered UART transmitter: producer-side valid/ready byte channel.
interface uart_tx_fifo_if;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: power-of-two byte FIFO feeding an 8N1 serialiser
// (LSB first, idle-high line). Define UART_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit (8E1, 11-bit frames).
module uart_tx_fifo #(
  parameter int unsigned DELAY_FRAMES = 234,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_fifo_if.slave        wr,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [FIFO_AW:0]     fifo_count
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = $clog2(DELAY_FRAMES);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  logic [7:0]      mem [DEPTH];
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] rptr;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            bit_end;
  logic [7:0]      head;

  assign fifo_count = wptr - rptr;
  assign empty      = (wptr == rptr);
  assign full       = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                      (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign wr.wr_ready = !rst && !full;
  assign push       = wr.wr_valid && wr.wr_ready;
  assign head       = mem[rptr[FIFO_AW-1:0]];
  assign bit_end    = (cnt == CW'(DELAY_FRAMES - 1));
  // The shifter is reloaded either from idle or at the end of a stop bit,
  // which is what makes back-to-back frames contiguous.
  assign pop        = !rst && !empty &&
                      ((state == IDLE) || ((state == STOP) && bit_end));
  assign busy       = !rst && ((state != IDLE) || !empty);

  // FIFO storage; contents need no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[FIFO_AW-1:0]] <= wr.wr_data;
  end

  // FIFO pointers; a simultaneous push and pop leave the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par;

  // Even parity captured when the byte enters the shifter, since the shifter is consumed.
  always_ff @(posedge clk) begin
    if (pop) par <= ^head;
  end
`endif

  // Serialiser FSM with registered line output and baud counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      uart_tx <= 1'b1;
    end else begin
      if (pop) shift <= head;
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          cnt     <= '0;
          if (!empty) begin
            state   <= START;
            uart_tx <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            uart_tx <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              uart_tx <= par;
`else
              state   <= STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              uart_tx <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            state   <= STOP;
            uart_tx <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (!empty) begin
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state   <= IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo;

  localparam int unsigned D     = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 2 ** AW;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FL = 11;
`else
  localparam int unsigned FL = 10;
`endif

  logic          clk;
  logic          rst;
  logic          uart_tx;
  logic          busy;
  logic [AW:0]   fifo_count;

  uart_tx_fifo_if ifc ();

  uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (ifc),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level for bit slot k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (FL == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Reference model: queue of waiting bytes plus the frame being sent and its
  // elapsed cycle count.
  logic [7:0] mq[$];
  logic [7:0] m_cur;
  bit         m_act = 1'b0;
  int         m_t   = 0;

  initial begin
    logic       s_rst, s_valid, acc;
    logic [7:0] s_data;
    logic       e_tx;
    forever begin
      @(posedge clk);
      s_rst   = rst;
      s_valid = ifc.wr_valid;
      s_data  = ifc.wr_data;
      if (s_rst) begin
        mq.delete();
        m_act = 1'b0;
        m_t   = 0;
      end else begin
        acc = s_valid && (mq.size() < DEPTH);
        if (m_act) begin
          m_t++;
          if (m_t == int'(FL * D)) begin
            if (mq.size() > 0) begin
              m_cur = mq.pop_front();
              m_t   = 0;
            end else begin
              m_act = 1'b0;
            end
          end
        end else if (mq.size() > 0) begin
          m_cur = mq.pop_front();
          m_act = 1'b1;
          m_t   = 0;
        end
        if (acc) mq.push_back(s_data);
      end
      #1;
      e_tx = m_act ? frame_bit(m_cur, m_t / int'(D)) : 1'b1;
      check("model_tx", 32'(uart_tx), 32'(e_tx));
      check("model_count", 32'(fifo_count), 32'(mq.size()));
      check("model_busy", 32'(busy), 32'(m_act || (mq.size() > 0)));
      check("model_ready", 32'(ifc.wr_ready), 32'(!s_rst && (mq.size() < DEPTH)));
    end
  end

  // Offer one byte starting at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] d);
    int n = 0;
    ifc.wr_valid = 1'b1;
    ifc.wr_data  = d;
    while (!ifc.wr_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("send_timeout", 32'(n), 32'(0));
    @(negedge clk);
    ifc.wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(busy), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_bits [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int acc, cnt, n, lows;

    rst          = 1'b1;
    ifc.wr_valid = 1'b0;
    ifc.wr_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(uart_tx), 32'(1));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_count", 32'(fifo_count), 32'(0));
    check("reset_ready", 32'(ifc.wr_ready), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(ifc.wr_ready), 32'(1));

    // Single byte 0x61: one cycle to start bit, each level held D cycles.
    send(8'h61);
    check("single_count1", 32'(fifo_count), 32'(1));
    check("single_idle_before", 32'(uart_tx), 32'(1));
    for (int j = 1; j <= int'(FL * D) + 1; j++) begin
      @(negedge clk);
      if (j % int'(D) == 5) check("single_bit", 32'(uart_tx), 32'(exp_bits[j / int'(D)]));
      if (j == int'(FL * D)) check("single_busy_last", 32'(busy), 32'(1));
      if (j == int'(FL * D) + 1) begin
        check("single_busy_drop", 32'(busy), 32'(0));
        check("single_tx_idle", 32'(uart_tx), 32'(1));
      end
    end
    wait_idle();

    // Full FIFO: hold valid with 0x00..0x13.
    acc = 0;
    n   = 0;
    ifc.wr_valid = 1'b1;
    ifc.wr_data  = 8'h00;
    while (ifc.wr_ready && n < 100) begin
      @(negedge clk);
      acc++;
      n++;
      ifc.wr_data = 8'(acc);
    end
    check("full_accepted", 32'(acc), 32'(17));
    check("full_count", 32'(fifo_count), 32'(16));
    cnt = 0;
    while (!ifc.wr_ready && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check("full_reassert_delay", 32'(cnt), 32'(FL * D - 15));
    n = 0;
    while (acc < 20 && n < 5000) begin
      if (ifc.wr_ready) begin
        @(negedge clk);
        acc++;
        ifc.wr_data = 8'(acc);
      end else begin
        @(negedge clk);
      end
      n++;
    end
    ifc.wr_valid = 1'b0;
    check("full_total", 32'(acc), 32'(20));
    wait_idle();

    // Back-to-back: two frames with no idle gap.
    @(negedge clk);
    send(8'h55);
    send(8'hAA);
    n = 0;
    while (uart_tx && n < 100) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    while (busy && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    check("b2b_active_cycles", 32'(cnt), 32'(2 * FL * D));
    wait_idle();

    // Reset during data bit 3 of the first of three queued bytes.
    @(negedge clk);
    send(8'h3C);
    send(8'hC3);
    send(8'h0F);
    repeat (33) @(negedge clk);
    check("rst_mid_tx_before", 32'(uart_tx), 32'(frame_bit(8'h3C, 4)));
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("rst_mid_tx", 32'(uart_tx), 32'(1));
    check("rst_mid_count", 32'(fifo_count), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (!uart_tx) lows++;
    end
    check("rst_no_frames", 32'(lows), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
